dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the CPU's MEM-stage data port.
- Accepts word read/write requests from EX/MEM (addr, write data, MemRd/MemWr) and services them with a fixed multi-cycle latency.
- Holds the pipeline with `stall_o` until the response is ready.
- Replaces the single-cycle data memory; the CPU stall network ORs `stall_o` into PC/IFID/IDEX/EXMEM hold and MEMWB bubble insertion.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, ≥ 4.
- LATENCY, 4, cycles from request acceptance to ack; legal range 1..15.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- addr_i  in  32  byte address from EX/MEM ALU result.
- WrData_i  in  32  store data.
- MemRd_i  in  1  load request.
- MemWr_i  in  1  store request.
- RdData_o  out  32  load data; valid in the ack cycle, then held.
- stall_o  out  1  pipeline hold request.
- ack_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle misalignment error pulse, coincident with ack_o.

Behaviour:
- Reset (async, rst_i=1), applied immediately:
  - state=IDLE, counter=0.
  - RdData_o=0, ack_o=0, err_o=0, stall_o=0.
  - Storage array is not cleared.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If MemRd_i|MemWr_i, capture addr, data, rd, wr into request regs.
  - stall_o is combinational high in this same cycle.
  - Next state: BUSY with counter=LATENCY-1 if LATENCY>1; DONE if LATENCY=1.
  - No request: stay IDLE, stall_o=0.
- BUSY:
  - stall_o=1; counter decrements each cycle.
  - At counter==1, go to DONE.
  - Inputs are ignored; captured copies are used.
- DONE:
  - stall_o=0, ack_o=1.
  - Write committed at the end of this cycle.
  - Read data driven on RdData_o in this cycle, registered on entry to DONE.
  - Next state IDLE. The pipeline advances on the DONE edge, so the next request is a new instruction.
- Latency: a request seen in IDLE at cycle t acks at cycle t+LATENCY; stall_o is high for cycles t..t+LATENCY-1.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Upper bits are ignored (wrap modulo DEPTH_WORDS).
- Misaligned (addr[1:0]≠0): err_o=1 with ack_o; no write; RdData_o=0.
- MemRd_i and MemWr_i both high: store wins, no read data update, err_o=1.
- RdData_o holds its last value across writes and idle cycles; it changes only on a read ack or reset.
- Reset mid-operation: the request is discarded, a pending write is not committed, and stall_o drops asynchronously.

Optional Feature:
- DMEM_PERF_CNT_EN adds three outputs, each 32-bit and saturating at 0xFFFFFFFF, cleared by reset:
  - rd_cnt_o: read acks.
  - wr_cnt_o: committed writes.
  - stall_cnt_o: cycles with stall_o=1.
- Without the macro, these ports and counters are absent.

Decomposition:
- Package dmem_pkg:
  - state enum typedef (IDLE/BUSY/DONE).
  - WORD_W=32, ADDR_LSB=2.
  - Counter width constant LAT_W=4.
- Sub-module dmem_sram:
  - Single-port synchronous array.
  - Ports: clk, we, index, wdata, rdata (registered).
  - No reset.

Test Plan:
- Reset then idle, no requests → stall_o=0, ack_o=0, RdData_o=0 for 10 cycles.
- LATENCY=4: store 0xDEADBEEF @0x10 at cycle 5, then load @0x10 → stall_o high in cycles 5–8, ack_o at 9; load acks 4 cycles after its accept with RdData_o=0xDEADBEEF.
- LATENCY=1: load @0x0 after store 0x12345678 → stall_o high 1 cycle, ack next cycle, RdData_o=0x12345678.
- Misaligned store @0x13 → err_o=1 with ack_o; a subsequent load @0x10 returns the prior value unchanged.
- Address wrap, DEPTH_WORDS=256: store 0xA5A5A5A5 @0x400, load @0x000 → 0xA5A5A5A5. Simultaneous MemRd_i=MemWr_i=1 → write performed, err_o=1.
- rst_i pulse during BUSY of store 0x55 @0x20 → stall_o drops immediately, state IDLE; later load @0x20 returns the old value. With DMEM_PERF_CNT_EN, wr_cnt_o stays 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
package dmem_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned ADDR_LSB = 2;
  localparam int unsigned LAT_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_sram.sv
// Single-port synchronous word array with registered read data and no reset.
module dmem_sram
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  index_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[index_i] <= wdata_i;
    end
    rdata_q <= mem_q[index_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory responder that stalls the pipeline until ack.
// Optional DMEM_PERF_CNT_EN adds saturating read/write/stall counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [WORD_W-1:0] WrData_i,
  input  logic              MemRd_i,
  input  logic              MemWr_i,
  output logic [WORD_W-1:0] RdData_o,
  output logic              stall_o,
  output logic              ack_o,
`ifdef DMEM_PERF_CNT_EN
  output logic [31:0]       rd_cnt_o,
  output logic [31:0]       wr_cnt_o,
  output logic [31:0]       stall_cnt_o,
`endif
  output logic              err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  state_e              state_q, state_d;
  logic [LAT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q;
  logic                mis_q, rd_q, wr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [WORD_W-1:0]   hold_q;
  logic                capture_c, stall_c, done_c, rd_ack_c, we_c;
  logic [IDX_W-1:0]    sram_idx_c;
  logic [WORD_W-1:0]   sram_rdata;
  logic                unused_addr_c;

  assign unused_addr_c = ^addr_i[31:IDX_W+ADDR_LSB];

  // Next-state, counter and capture decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_c = 1'b0;
    stall_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (MemRd_i || MemWr_i) begin
          capture_c = 1'b1;
          stall_c   = 1'b1;
          if (LATENCY > 1) begin
            state_d = BUSY;
            cnt_d   = LAT_W'(LATENCY - 1);
          end else begin
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q - LAT_W'(1);
        if (cnt_q == LAT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      mis_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= RdData_o;
      if (capture_c) begin
        idx_q   <= addr_i[IDX_W+ADDR_LSB-1:ADDR_LSB];
        mis_q   <= |addr_i[ADDR_LSB-1:0];
        rd_q    <= MemRd_i;
        wr_q    <= MemWr_i;
        wdata_q <= WrData_i;
      end
    end
  end

  // Array is read on the edge entering DONE, so index follows the live address in IDLE
  assign sram_idx_c = (state_q == IDLE) ? addr_i[IDX_W+ADDR_LSB-1:ADDR_LSB] : idx_q;
  assign done_c     = (state_q == DONE);
  assign we_c       = done_c && wr_q && !mis_q;
  assign rd_ack_c   = done_c && rd_q && !wr_q;

  dmem_sram #(.DEPTH(DEPTH_WORDS)) u_sram (
    .clk_i   (clk_i),
    .we_i    (we_c),
    .index_i (sram_idx_c),
    .wdata_i (wdata_q),
    .rdata_o (sram_rdata)
  );

  assign RdData_o = rd_ack_c ? (mis_q ? '0 : sram_rdata) : hold_q;
  assign ack_o    = done_c;
  assign err_o    = done_c && (mis_q || (rd_q && wr_q));
  assign stall_o  = stall_c && !rst_i;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] rd_cnt_q, wr_cnt_q, stall_cnt_q;

  // Saturating event counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (rd_ack_c && (rd_cnt_q != '1))    rd_cnt_q    <= rd_cnt_q + 32'd1;
      if (we_c && (wr_cnt_q != '1))        wr_cnt_q    <= wr_cnt_q + 32'd1;
      if (stall_o && (stall_cnt_q != '1))  stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign rd_cnt_o    = rd_cnt_q;
  assign wr_cnt_o    = wr_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance at LATENCY=4, one at LATENCY=1.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        mrd   [2];
  logic        mwr   [2];
  logic        stall [2];
  logic        ack   [2];
  logic        err   [2];
`ifdef DMEM_PERF_CNT_EN
  logic [31:0] rdc [2];
  logic [31:0] wrc [2];
  logic [31:0] stc [2];
`endif

  typedef struct {
    int          id;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS (256),
      .LATENCY     ((g == 0) ? 4 : 1)
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .addr_i      (addr[g]),
      .WrData_i    (wdata[g]),
      .MemRd_i     (mrd[g]),
      .MemWr_i     (mwr[g]),
      .RdData_o    (rdata[g]),
      .stall_o     (stall[g]),
      .ack_o       (ack[g]),
`ifdef DMEM_PERF_CNT_EN
      .rd_cnt_o    (rdc[g]),
      .wr_cnt_o    (wrc[g]),
      .stall_cnt_o (stc[g]),
`endif
      .err_o       (err[g])
    );

    // Response monitor: every ack pops one expected response
    always @(negedge clk) begin
      exp_t e;
      if (!rst && ack[g]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected dut%0d: ack with empty scoreboard", g);
        end else begin
          e = sb.pop_front();
          if (e.id != g || err[g] !== e.err || rdata[g] !== e.rdata) begin
            errors++;
            $display("FAIL resp dut%0d: got err=%b rdata=%h, expected dut%0d err=%b rdata=%h",
                     g, err[g], rdata[g], e.id, e.err, e.rdata);
          end
        end
      end
    end
  end

  task automatic do_req(input int k, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic e_err, input logic [31:0] e_rd);
    int lat;
    bit got;
    lat = (k == 0) ? 4 : 1;
    sb.push_back('{k, e_err, e_rd});
    @(posedge clk);
    #1;
    addr[k] = a; wdata[k] = d; mrd[k] = rd; mwr[k] = wr;
    got = 0;
    for (int n = 0; n <= lat + 3 && !got; n++) begin
      @(negedge clk);
      checks++;
      if (stall[k] !== (n < lat) || ack[k] !== (n == lat)) begin
        errors++;
        $display("FAIL timing dut%0d addr=%h cycle %0d: stall=%b ack=%b, expected stall=%b ack=%b",
                 k, a, n, stall[k], ack[k], (n < lat), (n == lat));
      end
      if (ack[k] === 1'b1) got = 1;
    end
    mrd[k] = 1'b0; mwr[k] = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout dut%0d addr=%h: no ack within %0d cycles", k, a, lat + 4);
    end
  endtask

  task automatic chk_quiet(input string name);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (stall[k] !== 1'b0 || ack[k] !== 1'b0 || err[k] !== 1'b0 || rdata[k] !== 32'h0) begin
        errors++;
        $display("FAIL %s dut%0d: stall=%b ack=%b err=%b rdata=%h, expected 0 0 0 00000000",
                 name, k, stall[k], ack[k], err[k], rdata[k]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      addr[k] = '0; wdata[k] = '0; mrd[k] = 1'b0; mwr[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk_quiet("idle");
    end

    // LATENCY=4 instance
    do_req(0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000);
    do_req(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF);
    do_req(0, 1'b0, 1'b1, 32'h0000_0013, 32'hFFFF_FFFF, 1'b1, 32'hDEAD_BEEF);
    do_req(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF);
    do_req(0, 1'b0, 1'b1, 32'h0000_0400, 32'hA5A5_A5A5, 1'b0, 32'hDEAD_BEEF);
    do_req(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hA5A5_A5A5);
    do_req(0, 1'b1, 1'b1, 32'h0000_0008, 32'h0BAD_F00D, 1'b1, 32'hA5A5_A5A5);
    do_req(0, 1'b1, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h0BAD_F00D);
    do_req(0, 1'b1, 1'b0, 32'h0000_0006, 32'h0,         1'b1, 32'h0000_0000);
    do_req(0, 1'b0, 1'b1, 32'h0000_0020, 32'h1111_1111, 1'b0, 32'h0000_0000);

    // LATENCY=1 instance
    do_req(1, 1'b0, 1'b1, 32'h0000_0000, 32'h1234_5678, 1'b0, 32'h0000_0000);
    do_req(1, 1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1234_5678);

    // Reset during BUSY of a store: write must be dropped
    @(posedge clk);
    #1;
    addr[0] = 32'h0000_0020; wdata[0] = 32'h0000_0055; mwr[0] = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (stall[0] !== 1'b1) begin
      errors++;
      $display("FAIL busy_stall dut0: stall=%b, expected 1", stall[0]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (stall[0] !== 1'b0 || ack[0] !== 1'b0 || rdata[0] !== 32'h0) begin
      errors++;
      $display("FAIL async_reset dut0: stall=%b ack=%b rdata=%h, expected 0 0 00000000",
               stall[0], ack[0], rdata[0]);
    end
    mwr[0] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_quiet("post_reset");
`ifdef DMEM_PERF_CNT_EN
    checks++;
    if (wrc[0] !== 32'h0) begin
      errors++;
      $display("FAIL wr_cnt dut0: got %0d, expected 0", wrc[0]);
    end
`endif
    do_req(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h1111_1111);

    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
